// File: rtl/dl_pipe_skid.sv
// dl_pipe_skid: two-entry valid/ready skid buffer between datapath pipeline stages.
// Every output comes straight from a flop, so out_ready does not reach in_ready
// combinationally and in_* does not reach out_* combinationally. The stage moves
// one beat per cycle with one cycle of forward latency. flush empties the stage
// synchronously.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst_n      asynchronous active-low reset
//   flush      synchronous squash of all held entries (highest priority)
//   in_valid   upstream beat offered
//   in_ready   stage can accept (registered; never depends on in_valid)
//   in_data    upstream payload
//   out_valid  beat available downstream (registered)
//   out_ready  downstream accepts
//   out_data   payload, taken from the main register
//   occ        number of entries held: 0, 1 or 2
module dl_pipe_skid #(
  parameter int unsigned          NUM_BITS = 32,
  parameter logic [NUM_BITS-1:0]  RST_VAL  = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] out_data,
  output logic [1:0]          occ
);

  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e              state_q, state_nx;
  logic [NUM_BITS-1:0] main_q, main_nx;
  logic [NUM_BITS-1:0] skid_q, skid_nx;
  logic                in_ready_nx;
  logic                out_valid_nx;
  logic [OCC_W-1:0]    occ_nx;
  logic                acc;
  logic                take;

  // The registered outputs already show the current state. acc and take
  // therefore use the registered ready/valid and add no path through logic.
  assign acc  = in_valid & in_ready;
  assign take = out_valid & out_ready;

  // State, payload registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      main_q    <= RST_VAL;
      skid_q    <= RST_VAL;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occ       <= '0;
    end else begin
      state_q   <= state_nx;
      main_q    <= main_nx;
      skid_q    <= skid_nx;
      in_ready  <= in_ready_nx;
      out_valid <= out_valid_nx;
      occ       <= occ_nx;
    end
  end

  assign out_data = main_q;

  // Next-state, payload steering and next output values
  always_comb begin
    state_nx     = state_q;
    main_nx      = main_q;
    skid_nx      = skid_q;
    in_ready_nx  = 1'b1;
    out_valid_nx = 1'b0;
    occ_nx       = '0;

    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          main_nx  = in_data;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (acc && take) begin
          main_nx = in_data;
        end else if (acc) begin
          // Downstream stalled: park the new beat behind the one on display
          skid_nx  = in_data;
          state_nx = FULL;
        end else if (take) begin
          state_nx = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so the only event is the drain of the older beat
        if (take) begin
          main_nx  = skid_q;
          state_nx = BUSY;
        end
      end
      default: begin
        state_nx = EMPTY;
        main_nx  = RST_VAL;
        skid_nx  = RST_VAL;
      end
    endcase

    // Squash wins over everything. A beat offered in the same cycle is dropped.
    if (flush) begin
      state_nx = EMPTY;
      main_nx  = RST_VAL;
      skid_nx  = RST_VAL;
    end

    in_ready_nx  = (state_nx != FULL);
    out_valid_nx = (state_nx != EMPTY);
    unique case (state_nx)
      BUSY:    occ_nx = OCC_W'(1);
      FULL:    occ_nx = OCC_W'(2);
      default: occ_nx = OCC_W'(0);
    endcase
  end

endmodule

// File: tb/tb_dl_pipe_skid.sv
// Directed and randomised self-checking bench for dl_pipe_skid.
module tb_dl_pipe_skid;

  localparam int unsigned NUM_BITS = 32;
  localparam logic [NUM_BITS-1:0] RST_VAL = 32'h0;

  logic                clk;
  logic                rst_n;
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [NUM_BITS-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [NUM_BITS-1:0] out_data;
  logic [1:0]          occ;

  int unsigned n_vec;
  int unsigned n_err;

  dl_pipe_skid #(.NUM_BITS(NUM_BITS), .RST_VAL(RST_VAL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occ       (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge. Sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  task automatic chk_state(input string tag, input logic ov, input logic ir,
                           input logic [1:0] oc, input logic [31:0] od);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
    chk({tag, ".occ"},       32'(occ),       32'(oc));
    chk({tag, ".out_data"},  out_data,       od);
  endtask

  logic [31:0] q[$];
  logic        m_acc;
  logic        m_take;
  logic [31:0] rd;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #12;
    chk_state("reset", 1'b0, 1'b1, 2'd0, RST_VAL);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: streaming at full rate, one-cycle lag
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 1'b1, 1'b0);
      step();
      chk_state($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, 32'(i));
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    chk_state("stream_drain", 1'b0, 1'b1, 2'd0, 32'h8);

    // 2/3: fill with A,B under stall, hold C off, then drain in order
    drive(1'b1, 32'hA, 1'b0, 1'b0);
    step();
    chk_state("fillA", 1'b1, 1'b1, 2'd1, 32'hA);
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    step();
    chk_state("fillB", 1'b1, 1'b0, 2'd2, 32'hA);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'hC, 1'b0, 1'b0);
      step();
      chk_state($sformatf("stall%0d", i), 1'b1, 1'b0, 2'd2, 32'hA);
    end
    drive(1'b1, 32'hC, 1'b1, 1'b0);
    step();
    chk_state("drainA", 1'b1, 1'b1, 2'd1, 32'hB);
    step();
    chk_state("drainB_accC", 1'b1, 1'b1, 2'd1, 32'hC);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    chk_state("drainC", 1'b0, 1'b1, 2'd0, 32'hC);

    // 4: flush from FULL while D is offered
    drive(1'b1, 32'hA, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    step();
    chk_state("refull", 1'b1, 1'b0, 2'd2, 32'hA);
    drive(1'b1, 32'hD, 1'b0, 1'b1);
    step();
    chk_state("flush", 1'b0, 1'b1, 2'd0, RST_VAL);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_state($sformatf("postflush%0d", i), 1'b0, 1'b1, 2'd0, RST_VAL);
    end

    // 4b: flush from BUSY while a take happens in the same cycle
    drive(1'b1, 32'h5, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h6, 1'b1, 1'b1);
    step();
    chk_state("flush_busy", 1'b0, 1'b1, 2'd0, RST_VAL);

    // 5: asynchronous reset between edges, mid-stream
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h12, 1'b0, 1'b0);
    step();
    chk_state("pre_arst", 1'b1, 1'b0, 2'd2, 32'h11);
    #2 rst_n = 1'b0;
    #1;
    chk_state("arst", 1'b0, 1'b1, 2'd0, RST_VAL);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h21, 1'b1, 1'b0);
    step();
    chk_state("post_arst1", 1'b1, 1'b1, 2'd1, 32'h21);
    drive(1'b1, 32'h22, 1'b1, 1'b0);
    step();
    chk_state("post_arst2", 1'b1, 1'b1, 2'd1, 32'h22);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    chk_state("post_arst_drain", 1'b0, 1'b1, 2'd0, 32'h22);

    // 6: random traffic against a FIFO model
    q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      rd = $urandom;
      drive(1'($urandom_range(0, 1)), rd, 1'($urandom_range(0, 3) != 0), 1'b0);
      m_acc  = in_valid && (q.size() < 2);
      m_take = out_ready && (q.size() > 0);
      chk("rnd.in_ready",  32'(in_ready),  32'(q.size() < 2));
      chk("rnd.out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) chk("rnd.out_data", out_data, q[0]);
      step();
      if (m_take) void'(q.pop_front());
      if (m_acc)  q.push_back(rd);
      chk("rnd.occ", 32'(occ), 32'(q.size()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
